// File: rtl/maj_ids_pkg.sv
// Shared types and default sizing for the major-PC anomaly scorer.
package maj_ids_pkg;

    localparam int DEF_FP_SIZE    = 64;
    localparam int DEF_FRAC_BITS  = 32;
    localparam int DEF_MAJ_PC_NUM = 10;
    localparam int DEF_CNT_W      = 16;

    typedef logic signed [DEF_FP_SIZE-1:0] fixed_t;

    localparam fixed_t FIX_MAX = {1'b0, {(DEF_FP_SIZE-1){1'b1}}};
    localparam fixed_t FIX_ONE = fixed_t'(64'sd1) <<< DEF_FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/maj_weighted_sq_term.sv
// One weighted squared-score term: floor(floor(s*s >> F) * max(w,0) >> F),
// with each stage clamped to the largest positive word.
module maj_weighted_sq_term
    import maj_ids_pkg::*;
#(
    parameter int FP_SIZE   = DEF_FP_SIZE,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic [FP_SIZE-1:0] i_score,
    input  logic [FP_SIZE-1:0] i_weight,
    output logic [FP_SIZE-1:0] o_term
);

    localparam int PW = 2 * FP_SIZE;
    localparam logic signed [PW-1:0] LIM = {{(FP_SIZE+1){1'b0}}, {(FP_SIZE-1){1'b1}}};

    logic signed [PW-1:0] w_score_x;
    logic signed [PW-1:0] w_sq_full;
    logic signed [PW-1:0] w_sq_shr;
    logic signed [PW-1:0] w_sq_x;
    logic signed [PW-1:0] w_wgt_x;
    logic signed [PW-1:0] w_prod_full;
    logic signed [PW-1:0] w_prod_shr;
    logic [FP_SIZE-1:0]   w_sq;
    logic [FP_SIZE-1:0]   w_wgt;

    // Square, weight, shift and clamp; all operands after squaring are non-negative
    always_comb begin
        w_score_x = {{FP_SIZE{i_score[FP_SIZE-1]}}, i_score};
        w_sq_full = w_score_x * w_score_x;
        w_sq_shr  = w_sq_full >>> FRAC_BITS;
        if (w_sq_shr > LIM) begin
            w_sq = LIM[FP_SIZE-1:0];
        end else begin
            w_sq = w_sq_shr[FP_SIZE-1:0];
        end

        if (i_weight[FP_SIZE-1]) begin
            w_wgt = {FP_SIZE{1'b0}};
        end else begin
            w_wgt = i_weight;
        end

        w_sq_x      = {{FP_SIZE{1'b0}}, w_sq};
        w_wgt_x     = {{FP_SIZE{1'b0}}, w_wgt};
        w_prod_full = w_sq_x * w_wgt_x;
        w_prod_shr  = w_prod_full >>> FRAC_BITS;
        if (w_prod_shr > LIM) begin
            o_term = LIM[FP_SIZE-1:0];
        end else begin
            o_term = w_prod_shr[FP_SIZE-1:0];
        end
    end

endmodule

// File: rtl/maj_anomaly_scorer.sv
// Sequential weighted squared-score statistic (one term per clock) with a
// threshold alert and a saturating count of delivered alerts.
module maj_anomaly_scorer
    import maj_ids_pkg::*;
#(
    parameter int FP_SIZE    = DEF_FP_SIZE,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int MAJ_PC_NUM = DEF_MAJ_PC_NUM,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FP_SIZE-1:0] in_scores [0:MAJ_PC_NUM-1],
    input  logic [FP_SIZE-1:0] inv_eig   [0:MAJ_PC_NUM-1],
    input  logic [FP_SIZE-1:0] threshold,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FP_SIZE-1:0] t_stat,
    output logic               alert,
    output logic [CNT_W-1:0]   alert_count
);

    localparam int IDX_W = (MAJ_PC_NUM > 1) ? $clog2(MAJ_PC_NUM) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(MAJ_PC_NUM - 1);
    localparam logic [FP_SIZE-1:0] ACC_MAX  = {1'b0, {(FP_SIZE-1){1'b1}}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FP_SIZE-1:0] r_buf [0:MAJ_PC_NUM-1];
    logic [IDX_W-1:0]   r_idx;
    logic [FP_SIZE-1:0] r_acc;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [FP_SIZE-1:0] r_t_stat;
    logic               r_alert;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic [FP_SIZE-1:0] w_term;
    logic [FP_SIZE:0]   w_sum;
    logic [FP_SIZE-1:0] w_acc_sat;
    logic               w_alert;

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign t_stat      = r_t_stat;
    assign alert       = r_alert;
    assign alert_count = r_cnt;

    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_idx == LAST_IDX);

    maj_weighted_sq_term #(
        .FP_SIZE   (FP_SIZE),
        .FRAC_BITS (FRAC_BITS)
    ) u_term (
        .i_score  (r_buf[r_idx]),
        .i_weight (inv_eig[r_idx]),
        .o_term   (w_term)
    );

    // Saturating accumulate; accumulator and term are both non-negative
    always_comb begin
        w_sum = {1'b0, r_acc} + {1'b0, w_term};
        if (w_sum[FP_SIZE] || w_sum[FP_SIZE-1]) begin
            w_acc_sat = ACC_MAX;
        end else begin
            w_acc_sat = w_sum[FP_SIZE-1:0];
        end
        w_alert = ($signed(w_acc_sat) > $signed(threshold));
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ACCUM;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCUM: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Score buffer, captured only on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAJ_PC_NUM; i++) begin
                r_buf[i] <= {FP_SIZE{1'b0}};
            end
        end else if (w_accept) begin
            r_buf <= in_scores;
        end
    end

    // Index, accumulator and registered handshake/result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= {IDX_W{1'b0}};
            r_acc       <= {FP_SIZE{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_t_stat    <= {FP_SIZE{1'b0}};
            r_alert     <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_idx <= {IDX_W{1'b0}};
                r_acc <= {FP_SIZE{1'b0}};
            end else if (r_state == ACCUM) begin
                r_acc <= w_acc_sat;
                if (w_last) begin
                    r_idx    <= {IDX_W{1'b0}};
                    r_t_stat <= w_acc_sat;
                    r_alert  <= w_alert;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    // Saturating count of alerts actually handed to the consumer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == DONE) && out_ready && r_alert && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_maj_anomaly_scorer.sv
// Self-checking bench: directed literal cases plus randomized traffic compared
// every cycle against a transaction-level model of the scorer.
module tb_maj_anomaly_scorer;

    localparam int FP   = 32;
    localparam int FRAC = 16;
    localparam int N    = 4;
    localparam int CW   = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [FP-1:0] in_scores [0:N-1];
    logic [FP-1:0] inv_eig   [0:N-1];
    logic [FP-1:0] threshold;
    logic          in_ready;
    logic          out_valid;
    logic [FP-1:0] t_stat;
    logic          alert;
    logic [CW-1:0] alert_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maj_anomaly_scorer #(
        .FP_SIZE    (FP),
        .FRAC_BITS  (FRAC),
        .MAJ_PC_NUM (N),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_scores   (in_scores),
        .inv_eig     (inv_eig),
        .threshold   (threshold),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .t_stat      (t_stat),
        .alert       (alert),
        .alert_count (alert_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // T = min(MAX, sum of min(MAX, floor(min(MAX, floor(s^2/2^F)) * max(w,0) / 2^F)))
    function automatic longint ref_stat(input logic [FP-1:0] s [0:N-1], input logic [FP-1:0] w [0:N-1]);
        longint maxv = 64'sh0000_0000_7FFF_FFFF;
        longint total = 0;
        for (int i = 0; i < N; i++) begin
            longint sv = longint'($signed(s[i]));
            longint wv = longint'($signed(w[i]));
            longint sq = (sv * sv) >>> FRAC;
            longint p;
            if (sq > maxv) sq = maxv;
            if (wv < 0) wv = 0;
            p = (sq * wv) >>> FRAC;
            if (p > maxv) p = maxv;
            total += p;
        end
        if (total > maxv) total = maxv;
        return total;
    endfunction

    // Transaction-level model: accept, N-cycle compute, hold until consumed
    logic          m_ready = 1'b1;
    logic          m_vld   = 1'b0;
    logic [FP-1:0] m_t     = 32'h0;
    logic          m_alert = 1'b0;
    logic [CW-1:0] m_cnt   = 4'h0;
    int            m_left  = 0;
    logic [FP-1:0] m_snap [0:N-1];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ready <= 1'b1;
            m_vld   <= 1'b0;
            m_t     <= 32'h0;
            m_alert <= 1'b0;
            m_cnt   <= 4'h0;
            m_left  <= 0;
        end else if (m_ready && in_valid) begin
            m_ready <= 1'b0;
            m_left  <= N;
            m_snap  <= in_scores;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_vld   <= 1'b1;
                m_t     <= 32'(ref_stat(m_snap, inv_eig));
                m_alert <= (ref_stat(m_snap, inv_eig) > longint'($signed(threshold)));
            end
        end else if (m_vld && out_ready) begin
            m_vld   <= 1'b0;
            m_ready <= 1'b1;
            if (m_alert && (m_cnt != 4'hF)) m_cnt <= m_cnt + 4'h1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        chk("out_valid", 64'(out_valid), 64'(m_vld));
        chk("alert_count", 64'(alert_count), 64'(m_cnt));
        if (m_vld) begin
            chk("t_stat", 64'(t_stat), 64'(m_t));
            chk("alert", 64'(alert), 64'(m_alert));
        end
    end

    task automatic set_scores(input logic [FP-1:0] a, input logic [FP-1:0] b,
                              input logic [FP-1:0] c, input logic [FP-1:0] d);
        in_scores[0] = a;
        in_scores[1] = b;
        in_scores[2] = c;
        in_scores[3] = d;
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge after accept
    task automatic start_vec(input logic [FP-1:0] thr);
        threshold = thr;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_vec(input string tag, input logic [FP-1:0] thr,
                          input logic [FP-1:0] exp_t, input logic exp_a);
        int cyc;
        start_vec(thr);
        wait_out(cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'd5);
        chk({tag, "_t_stat"}, 64'(t_stat), 64'(exp_t));
        chk({tag, "_alert"}, 64'(alert), 64'(exp_a));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [FP-1:0] rand_score();
        logic [FP-1:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom();
            1, 2: begin
                v = 32'($urandom_range(0, 32'h0004_0000));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    function automatic logic [FP-1:0] rand_weight();
        logic [FP-1:0] v;
        case ($urandom_range(0, 5))
            0: v = $urandom();
            1: v = 32'hFFFF_0000;
            default: v = 32'($urandom_range(0, 32'h0002_0000));
        endcase
        return v;
    endfunction

    initial begin
        int cyc;
        for (int i = 0; i < N; i++) begin
            inv_eig[i]   = 32'h0001_0000;
            in_scores[i] = 32'h0;
        end
        threshold = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_t_stat", 64'(t_stat), 64'd0);
        chk("rst_alert", 64'(alert), 64'd0);
        chk("rst_count", 64'(alert_count), 64'd0);

        set_scores(32'h0001_0000, 32'h0002_0000, 32'h0, 32'h0);
        do_vec("basic", 32'h0004_0000, 32'h0005_0000, 1'b1);
        chk("basic_count", 64'(alert_count), 64'd1);

        do_vec("boundary", 32'h0005_0000, 32'h0005_0000, 1'b0);
        chk("boundary_count", 64'(alert_count), 64'd1);

        set_scores(32'hFFFF_0000, 32'h0, 32'h0, 32'h0);
        inv_eig[0] = 32'h0002_0000;
        do_vec("negscore", 32'h0004_0000, 32'h0002_0000, 1'b0);
        inv_eig[0] = 32'hFFFF_0000;
        do_vec("negweight", 32'h0, 32'h0, 1'b0);
        inv_eig[0] = 32'h0001_0000;

        set_scores(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        do_vec("saturate", 32'h7FFF_FFFE, 32'h7FFF_FFFF, 1'b1);
        chk("saturate_count", 64'(alert_count), 64'd2);

        // Backpressure: result held while out_ready is low; busy input ignored
        set_scores(32'h0001_0000, 32'h0002_0000, 32'h0, 32'h0);
        start_vec(32'h0004_0000);
        wait_out(cyc);
        chk("bp_latency", 64'(cyc), 64'd5);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            set_scores(32'h0003_0000, 32'h0003_0000, 32'h0003_0000, 32'h0003_0000);
            @(negedge clk);
            chk("bp_t_stat", 64'(t_stat), 64'h0005_0000);
            chk("bp_alert", 64'(alert), 64'd1);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_count", 64'(alert_count), 64'd3);

        // Alert counter must stick at all-ones
        set_scores(32'h0001_0000, 32'h0002_0000, 32'h0, 32'h0);
        for (int k = 0; k < 13; k++) begin
            do_vec("cnt", 32'h0004_0000, 32'h0005_0000, 1'b1);
        end
        chk("cnt_saturated", 64'(alert_count), 64'hF);

        // Reset two cycles into accumulation
        set_scores(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h0);
        start_vec(32'h0);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_count", 64'(alert_count), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_scores(32'h0001_0000, 32'h0002_0000, 32'h0, 32'h0);
        do_vec("postrst", 32'h0004_0000, 32'h0005_0000, 1'b1);
        chk("postrst_count", 64'(alert_count), 64'd1);

        // Randomized traffic; weights and threshold only move while idle
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) in_scores[i] = rand_score();
            if (m_ready) begin
                for (int i = 0; i < N; i++) inv_eig[i] = rand_weight();
                if ($urandom_range(0, 3) == 0) threshold = $urandom();
                else threshold = 32'($urandom_range(0, 32'h0010_0000));
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
